// File: rtl/inv_sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// inv_sub_bytes_seq
//
// Sequential AES InvSubBytes stage for the iterative decryption round. It sits
// between InvShiftRows and AddRoundKey. One 128-bit state word is accepted over
// a valid/ready handshake, and BYTES_PER_CYCLE bytes are substituted per clock.
// Byte 0 ([127:120]) is processed first. The result is returned over a second
// valid/ready handshake.
//
// Parameters
//   BYTES_PER_CYCLE  bytes substituted per clock (1, 2, 4, 8 or 16)
//   CNT_W            byte-group counter width (>= log2(16/BYTES_PER_CYCLE), >= 1)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   in_byte holds a valid state word
//   in_ready   block can accept a state word (IDLE)
//   in_byte    input state, byte 0 = [127:120], byte 15 = [7:0]
//   mode_fwd   (only with INV_SUB_BYTES_FWD_EN) 1 = forward S-box, 0 = inverse;
//              sampled on the accept edge
//   out_valid  out_byte holds a completed result (DONE)
//   out_ready  downstream accepts the result
//   out_byte   substituted state, same byte ordering as in_byte
//   busy       substitution in progress (BUSY)
//
// Optional feature macro: INV_SUB_BYTES_FWD_EN (adds mode_fwd and forward S-box)
// -----------------------------------------------------------------------------
module inv_sub_bytes_seq #(
    parameter int BYTES_PER_CYCLE = 4,
    parameter int CNT_W           = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_byte,
`ifdef INV_SUB_BYTES_FWD_EN
    input  logic         mode_fwd,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_byte,
    output logic         busy
);

    // ---------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ---------------------------------------------------------------------
    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
        $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end else if (CNT_W < 1 || (1 << CNT_W) < (16 / BYTES_PER_CYCLE)) begin : g_bad_cnt
        $error("inv_sub_bytes_seq: CNT_W too small for 16/BYTES_PER_CYCLE groups");
    end

    localparam int unsigned   GROUPS    = 16 / BYTES_PER_CYCLE;
    localparam int unsigned   LW        = 8 * BYTES_PER_CYCLE;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(GROUPS - 1);
    localparam logic [127:0]  LANE_ONES = {128{1'b1}} >> (128 - LW);

    // ---------------------------------------------------------------------
    // GF(2^8) arithmetic (AES polynomial x^8 + x^4 + x^3 + x + 1)
    // ---------------------------------------------------------------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = '0;
        x = a;
        y = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; 0 maps to 0 naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    // InvSbox(b) = inverse(InvAffine(b)); InvAffine = rotl1 ^ rotl3 ^ rotl6 ^ 0x05
    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        logic [7:0] t;
        t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

`ifdef INV_SUB_BYTES_FWD_EN
    // Sbox(b) = Affine(inverse(b)); Affine = b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        logic [7:0] v;
        v = gf_inv(b);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
               {v[3:0], v[7:4]} ^ 8'h63;
    endfunction
`endif

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state;
    logic [127:0]       work;
    logic [CNT_W-1:0]   cnt;
`ifdef INV_SUB_BYTES_FWD_EN
    logic               mode_q;
`endif

    // ---------------------------------------------------------------------
    // Lane datapath: the current byte group is brought down to the low bits
    // (rsh), substituted by BYTES_PER_CYCLE parallel lookups, and shifted back
    // into place. rsh never goes negative because cnt <= GROUPS-1.
    // ---------------------------------------------------------------------
    logic [7:0]    rsh;
    logic [LW-1:0] sel;
    logic [LW-1:0] lane_bits;
    logic [127:0]  next_work;

    always_comb begin
        rsh = 8'(128 - LW) - 8'(cnt) * 8'(LW);
        sel = LW'(work >> rsh);
        lane_bits = '0;
        for (int unsigned j = 0; j < BYTES_PER_CYCLE; j++) begin
`ifdef INV_SUB_BYTES_FWD_EN
            lane_bits[LW-1-8*j -: 8] = mode_q ? sbox_fwd(sel[LW-1-8*j -: 8])
                                              : sbox_inv(sel[LW-1-8*j -: 8]);
`else
            lane_bits[LW-1-8*j -: 8] = sbox_inv(sel[LW-1-8*j -: 8]);
`endif
        end
        next_work = (work & ~(LANE_ONES << rsh)) | (128'(lane_bits) << rsh);
    end

    // ---------------------------------------------------------------------
    // Control FSM with registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            work      <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_byte  <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
            mode_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work     <= in_byte;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef INV_SUB_BYTES_FWD_EN
                        mode_q   <= mode_fwd;
`endif
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    work <= next_work;
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        out_byte  <= next_work;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    // in_ready rises only after the handshake edge, so a new
                    // word is never accepted on the same edge.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// tb_inv_sub_bytes_seq
//
// Self-checking bench for inv_sub_bytes_seq. Five instances cover
// BYTES_PER_CYCLE = 1, 2, 4, 8, 16. Expected results come from S-box tables
// built here from the GF(2^8) definition (forward S-box by brute-force inverse
// plus affine map, inverse S-box by inverting that table).
// Honours INV_SUB_BYTES_FWD_EN when defined.
// -----------------------------------------------------------------------------
module tb_inv_sub_bytes_seq;

    localparam int NDUT = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [NDUT];
    logic         in_ready  [NDUT];
    logic [127:0] in_byte   [NDUT];
    logic         out_valid [NDUT];
    logic         out_ready [NDUT];
    logic [127:0] out_byte  [NDUT];
    logic         busy      [NDUT];
`ifdef INV_SUB_BYTES_FWD_EN
    logic         mode_fwd  [NDUT];
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] s_tab   [256];
    logic [7:0] inv_tab [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        inv_sub_bytes_seq #(
            .BYTES_PER_CYCLE(1 << g),
            .CNT_W(4)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .in_valid(in_valid[g]),
            .in_ready(in_ready[g]),
            .in_byte(in_byte[g]),
`ifdef INV_SUB_BYTES_FWD_EN
            .mode_fwd(mode_fwd[g]),
`endif
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_byte(out_byte[g]),
            .busy(busy[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (prod[i]) prod = prod ^ (16'h011B << (i - 8));
        return prod[7:0];
    endfunction

    task automatic build_tables();
        logic [7:0] inv, r;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                r[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^
                       inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
            s_tab[x] = r ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_tab[s_tab[x]] = 8'(x);
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] w, input bit fwd);
        logic [127:0] r;
        logic [7:0]   b;
        for (int i = 0; i < 16; i++) begin
            b = w[127 - 8*i -: 8];
            r[127 - 8*i -: 8] = fwd ? s_tab[b] : inv_tab[b];
        end
        return r;
    endfunction

    // ---------------- transaction driver ----------------
    // Entered and left at posedge+1 with the selected DUT idle.
    task automatic run_txn(input int d, input logic [127:0] data, input bit fwd,
                           input bit tog, input int hold, input logic [127:0] exp);
        int n, lat, bcnt;
        logic [127:0] held;
        n = 16 >> d;
        check($sformatf("in_ready_idle[%0d]", d), 128'(in_ready[d]), 128'(1));
        in_byte[d]  = data;
        in_valid[d] = 1'b1;
`ifdef INV_SUB_BYTES_FWD_EN
        mode_fwd[d] = fwd;
`endif
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        in_byte[d]  = ~data;
        lat = 0;
        bcnt = 0;
        while (!out_valid[d] && lat < 40) begin
            if (busy[d]) bcnt++;
            in_valid[d]  = 1'($urandom);   // ignored in BUSY
            out_ready[d] = 1'($urandom);   // no effect in BUSY
`ifdef INV_SUB_BYTES_FWD_EN
            if (tog) mode_fwd[d] = ~mode_fwd[d];
`endif
            @(posedge clk); #1;
            lat++;
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b0;
        check($sformatf("latency[%0d]", d), 128'(lat), 128'(n));
        check($sformatf("busy_cycles[%0d]", d), 128'(bcnt), 128'(n));
        check($sformatf("out_byte[%0d]", d), out_byte[d], exp);
        check($sformatf("busy_done[%0d]", d), 128'(busy[d]), 128'(0));
        check($sformatf("in_ready_done[%0d]", d), 128'(in_ready[d]), 128'(0));
        held = out_byte[d];
        for (int i = 0; i < hold; i++) begin
            in_valid[d] = (i == 3);        // pulse while DONE must be ignored
            @(posedge clk); #1;
            check($sformatf("hold_valid[%0d]", d), 128'(out_valid[d]), 128'(1));
            check($sformatf("hold_ready[%0d]", d), 128'(in_ready[d]), 128'(0));
            check($sformatf("hold_stable[%0d]", d), out_byte[d], held);
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        check($sformatf("handshake_valid[%0d]", d), 128'(out_valid[d]), 128'(0));
        check($sformatf("handshake_ready[%0d]", d), 128'(in_ready[d]), 128'(1));
        check($sformatf("handshake_busy[%0d]", d), 128'(busy[d]), 128'(0));
        check($sformatf("handshake_out[%0d]", d), out_byte[d], exp);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] data;
        bit           fwd;
        int           seen;

        rst = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
            in_byte[i]   = '0;
`ifdef INV_SUB_BYTES_FWD_EN
            mode_fwd[i]  = 1'b0;
`endif
        end
        build_tables();

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("rst_in_ready[%0d]", i), 128'(in_ready[i]), 128'(1));
            check($sformatf("rst_out_valid[%0d]", i), 128'(out_valid[i]), 128'(0));
            check($sformatf("rst_busy[%0d]", i), 128'(busy[i]), 128'(0));
            check($sformatf("rst_out_byte[%0d]", i), out_byte[i], 128'h0);
        end
        @(posedge clk); #1;

        // All-0x63 word on BPC=4
        run_txn(2, {16{8'h63}}, 1'b0, 1'b0, 0, 128'h0);

        // Mixed vector on every width
        for (int d = 0; d < NDUT; d++)
            run_txn(d, 128'h00112233_63636363_7C7C7C7C_16161616, 1'b0, 1'b0, 0,
                    128'h52E39466_00000000_01010101_FFFFFFFF);

        // Backpressure on BPC=4
        data = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_txn(2, data, 1'b0, 1'b0, 10, ref_sub(data, 1'b0));

        // Reset on the 2nd BUSY cycle of BPC=1
        data = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_byte[0]  = data;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy_before", 128'(busy[0]), 128'(1));
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 128'(in_ready[0]), 128'(1));
        check("midrst_busy", 128'(busy[0]), 128'(0));
        check("midrst_out_valid", 128'(out_valid[0]), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid[0]) seen++;
        end
        check("midrst_no_output", 128'(seen), 128'(0));
        run_txn(0, data, 1'b0, 1'b0, 1, ref_sub(data, 1'b0));

`ifdef INV_SUB_BYTES_FWD_EN
        run_txn(2, {16{8'h00}}, 1'b1, 1'b0, 0, {16{8'h63}});
        run_txn(2, {16{8'h63}}, 1'b0, 1'b0, 0, {16{8'h00}});
        run_txn(0, {16{8'h53}}, 1'b1, 1'b1, 0, {16{8'hED}});
        run_txn(1, {16{8'h00}}, 1'b0, 1'b1, 0, {16{8'h52}});
`endif

        // Randomized traffic across all widths
        for (int t = 0; t < 30; t++) begin
            int d;
            d = int'($urandom_range(0, NDUT - 1));
            data = {$urandom(), $urandom(), $urandom(), $urandom()};
`ifdef INV_SUB_BYTES_FWD_EN
            fwd = 1'($urandom);
`else
            fwd = 1'b0;
`endif
            run_txn(d, data, fwd, 1'($urandom), int'($urandom_range(0, 3)),
                    ref_sub(data, fwd));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
